// File: rtl/csa_accum_ctrl.sv
// Carry-save multi-beat accumulator: each beat is compressed to sum/carry and merged without
// a carry-propagate add; a single resolve cycle produces the binary result.
module csa_accum_ctrl #(
  parameter int unsigned N         = 4,
  parameter int unsigned WIDTH_I   = 8,
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned WIDTH_O   = WIDTH_I + $clog2(N) + $clog2(MAX_BEATS)
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic [N-1:0][WIDTH_I-1:0]          operands_i,
  input  logic                               last_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [WIDTH_O-1:0]                 result_o,
  output logic [$clog2(MAX_BEATS+1)-1:0]     beats_o,
  output logic                               overflow_o
);

  localparam int unsigned BeatsW = $clog2(MAX_BEATS + 1);
  localparam logic [BeatsW-1:0] MaxCnt = BeatsW'(MAX_BEATS);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StAccum   = 2'd1;
  localparam logic [1:0] StResolve = 2'd2;
  localparam logic [1:0] StDone    = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [WIDTH_O-1:0] sum_q, sum_d, carry_q, carry_d;
  logic [WIDTH_O-1:0] result_q, result_d;
  logic [BeatsW-1:0]  count_q, count_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH_O-1:0] tree_s, tree_c, tree_op, tree_ns, tree_nc;
  logic [WIDTH_O-1:0] m1_s, m1_c, m2_s, m2_c;
  logic               accept;

  assign in_ready_o  = (state_q == StIdle) || (state_q == StAccum);
  assign out_valid_o = (state_q == StDone);
  assign accept      = in_valid_i && in_ready_o;
  assign result_o    = result_q;
  assign beats_o     = count_q;
  assign overflow_o  = ovf_q;

  // Chain of 3:2 compressors reducing the beat's operands to a redundant sum/carry pair.
  always_comb begin
    tree_s  = WIDTH_O'(operands_i[0]);
    tree_c  = '0;
    tree_op = '0;
    tree_ns = '0;
    tree_nc = '0;
    for (int unsigned i = 1; i < N; i++) begin
      tree_op = WIDTH_O'(operands_i[i]);
      tree_ns = tree_s ^ tree_c ^ tree_op;
      tree_nc = ((tree_s & tree_c) | (tree_s & tree_op) | (tree_c & tree_op)) << 1;
      tree_s  = tree_ns;
      tree_c  = tree_nc;
    end
  end

  // 4:2 compressor built from two 3:2 stages merging the beat into the accumulator.
  always_comb begin
    m1_s = tree_s ^ tree_c ^ sum_q;
    m1_c = ((tree_s & tree_c) | (tree_s & sum_q) | (tree_c & sum_q)) << 1;
    m2_s = m1_s ^ m1_c ^ carry_q;
    m2_c = ((m1_s & m1_c) | (m1_s & carry_q) | (m1_c & carry_q)) << 1;
  end

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    result_d = result_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sum_d   = tree_s;
          carry_d = tree_c;
          count_d = BeatsW'(1);
          ovf_d   = 1'b0;
          state_d = last_i ? StResolve : StAccum;
        end
      end
      StAccum: begin
        if (accept) begin
          sum_d   = m2_s;
          carry_d = m2_c;
          if (count_q == MaxCnt) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + BeatsW'(1);
          end
          state_d = last_i ? StResolve : StAccum;
        end
      end
      StResolve: begin
        result_d = sum_q + carry_q;
        state_d  = StDone;
      end
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      sum_q    <= '0;
      carry_q  <= '0;
      result_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Self-checking bench: directed and random transactions against an arithmetic reference model.
module tb_csa_accum_ctrl;

  localparam int unsigned N         = 4;
  localparam int unsigned WIDTH_I   = 8;
  localparam int unsigned MAX_BEATS = 16;
  localparam int unsigned WIDTH_O   = 14;

  logic                      clk_i = 1'b0;
  logic                      rst_ni = 1'b0;
  logic                      in_valid_i = 1'b0;
  logic                      in_ready_o;
  logic [N-1:0][WIDTH_I-1:0] operands_i = '0;
  logic                      last_i = 1'b0;
  logic                      out_valid_o;
  logic                      out_ready_i = 1'b0;
  logic [WIDTH_O-1:0]        result_o;
  logic [4:0]                beats_o;
  logic                      overflow_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [N-1:0][WIDTH_I-1:0] beat_q[$];

  csa_accum_ctrl #(
    .N         (N),
    .WIDTH_I   (WIDTH_I),
    .MAX_BEATS (MAX_BEATS)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .operands_i  (operands_i),
    .last_i      (last_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .beats_o     (beats_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_beat(input int a, input int b, input int c, input int d);
    logic [N-1:0][WIDTH_I-1:0] w;
    w[0] = WIDTH_I'(a);
    w[1] = WIDTH_I'(b);
    w[2] = WIDTH_I'(c);
    w[3] = WIDTH_I'(d);
    beat_q.push_back(w);
  endtask

  // Sends every queued beat (last on the final one), then checks latency, result and hold.
  task automatic run_txn(input int gap_min, input int gap_max, input int hold);
    int          n;
    int          gap;
    longint      total;
    logic [31:0] exp_res;
    logic [31:0] exp_beats;
    logic [31:0] exp_ovf;
    n     = beat_q.size();
    total = 0;
    for (int b = 0; b < n; b++)
      for (int k = 0; k < int'(N); k++) total += longint'(beat_q[b][k]);
    exp_res   = 32'(total % (longint'(1) << WIDTH_O));
    exp_beats = (n > int'(MAX_BEATS)) ? MAX_BEATS : 32'(n);
    exp_ovf   = (n > int'(MAX_BEATS)) ? 32'd1 : 32'd0;

    for (int b = 0; b < n; b++) begin
      gap = $urandom_range(gap_max, gap_min);
      in_valid_i = 1'b0;
      for (int g = 0; g < gap; g++) begin
        step();
        check_eq("gap_ready", in_ready_o, 1);
        check_eq("gap_out_valid", out_valid_o, 0);
      end
      operands_i = beat_q[b];
      last_i     = (b == n - 1);
      in_valid_i = 1'b1;
      check_eq("in_ready", in_ready_o, 1);
      step();
    end
    in_valid_i = 1'b0;
    last_i     = 1'b0;
    check_eq("resolve_out_valid", out_valid_o, 0);
    check_eq("resolve_in_ready", in_ready_o, 0);
    step();
    check_eq("out_valid", out_valid_o, 1);
    check_eq("result", result_o, exp_res);
    check_eq("beats", beats_o, exp_beats);
    check_eq("overflow", overflow_o, exp_ovf);
    for (int h = 0; h < hold; h++) begin
      step();
      check_eq("hold_valid", out_valid_o, 1);
      check_eq("hold_result", result_o, exp_res);
      check_eq("hold_beats", beats_o, exp_beats);
      check_eq("hold_overflow", overflow_o, exp_ovf);
      check_eq("hold_in_ready", in_ready_o, 0);
    end
    out_ready_i = 1'b1;
    check_eq("done_in_ready", in_ready_o, 0);
    step();
    out_ready_i = 1'b0;
    check_eq("post_out_valid", out_valid_o, 0);
    check_eq("post_in_ready", in_ready_o, 1);
    beat_q.delete();
  endtask

  initial begin
    #2;
    check_eq("rst_result", result_o, 0);
    check_eq("rst_beats", beats_o, 0);
    check_eq("rst_overflow", overflow_o, 0);
    check_eq("rst_out_valid", out_valid_o, 0);
    step();
    rst_ni = 1'b1;
    step();
    check_eq("rst_in_ready", in_ready_o, 1);

    push_beat(1, 2, 3, 4);
    run_txn(0, 0, 0);

    for (int b = 0; b < 16; b++) push_beat(255, 255, 255, 255);
    run_txn(0, 0, 0);

    for (int b = 0; b < 17; b++) push_beat(255, 255, 255, 255);
    run_txn(0, 0, 5);

    // Abort a partial transaction with reset while a previous result is still registered.
    for (int b = 0; b < 3; b++) begin
      operands_i = {8'd9, 8'd9, 8'd9, 8'd9};
      last_i     = 1'b0;
      in_valid_i = 1'b1;
      step();
    end
    in_valid_i = 1'b0;
    rst_ni     = 1'b0;
    #2;
    check_eq("mid_rst_result", result_o, 0);
    check_eq("mid_rst_beats", beats_o, 0);
    check_eq("mid_rst_overflow", overflow_o, 0);
    check_eq("mid_rst_out_valid", out_valid_o, 0);
    step();
    rst_ni = 1'b1;
    step();
    check_eq("mid_rst_in_ready", in_ready_o, 1);
    push_beat(1, 1, 1, 1);
    run_txn(0, 0, 0);

    push_beat(1, 2, 3, 4);
    push_beat(5, 6, 7, 8);
    run_txn(3, 3, 0);
    push_beat(1, 2, 3, 4);
    push_beat(5, 6, 7, 8);
    run_txn(0, 0, 0);

    for (int t = 0; t < 25; t++) begin
      int nb;
      nb = $urandom_range(20, 1);
      for (int b = 0; b < nb; b++)
        push_beat($urandom_range(255, 0), $urandom_range(255, 0),
                  $urandom_range(255, 0), $urandom_range(255, 0));
      run_txn(0, 3, $urandom_range(3, 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
